// File: rtl/arr_port_arbiter.sv
// arr_port_arbiter: shares one single-port array (combinational read,
// synchronous write) between the host control interface and the kernel FSM.
// At most one access per cycle. Round-robin arbitration, where a requester can
// keep the grant for up to MAX_HOLD consecutive cycles while the other waits.
//
// Optional feature: define ARB_HOST_PRIORITY_EN to make the host always win
// when it requests. The owner, hold count and last-winner state are still
// updated in that mode, but they no longer decide the grant.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   host_req/we/addr/wdata       host request; held stable until host_gnt
//   host_gnt                     host access performed this cycle (comb)
//   host_rvalid/host_rdata       registered read return, pulses the cycle after gnt
//   kern_*                       same set of signals for the kernel FSM
//   mem_we/addr/wdata            array drive, muxed from the granted requester
//   mem_rdata                    array combinational read data
module arr_port_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              kern_req,
    input  logic              kern_we,
    input  logic [ADDR_W-1:0] kern_addr,
    input  logic [DATA_W-1:0] kern_wdata,
    output logic              kern_gnt,
    output logic              kern_rvalid,
    output logic [DATA_W-1:0] kern_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned      HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_KERN = 2'd2
    } owner_t;

    owner_t            owner_q, owner_d, win;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              last_kern_q, last_kern_d;   // 1: kernel won the last grant

    // Arbitration, memory mux and next-state
    always_comb begin
        host_gnt    = 1'b0;
        kern_gnt    = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        owner_d     = owner_q;
        hold_d      = hold_q;
        last_kern_d = last_kern_q;
        win         = OWN_NONE;

        if (host_req && kern_req) begin
`ifdef ARB_HOST_PRIORITY_EN
            host_gnt = 1'b1;
`else
            case (owner_q)
                OWN_HOST: begin
                    if (hold_q < HOLD_MAX) host_gnt = 1'b1;
                    else                   kern_gnt = 1'b1;
                end
                OWN_KERN: begin
                    if (hold_q < HOLD_MAX) kern_gnt = 1'b1;
                    else                   host_gnt = 1'b1;
                end
                default: begin
                    // No current owner: the side that did not win last goes first
                    if (last_kern_q) host_gnt = 1'b1;
                    else             kern_gnt = 1'b1;
                end
            endcase
`endif
        end else begin
            host_gnt = host_req;
            kern_gnt = kern_req;
        end

        if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            win       = OWN_HOST;
        end else if (kern_gnt) begin
            mem_we    = kern_we;
            mem_addr  = kern_addr;
            mem_wdata = kern_wdata;
            win       = OWN_KERN;
        end

        if (win != OWN_NONE) begin
            if (owner_q == win) begin
                hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
            end else begin
                owner_d = win;
                hold_d  = HOLD_W'(1);
            end
            last_kern_d = kern_gnt;
        end else begin
            owner_d = OWN_NONE;
            hold_d  = '0;
        end
    end

    // Arbitration state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            hold_q      <= '0;
            last_kern_q <= 1'b1;
        end else begin
            owner_q     <= owner_d;
            hold_q      <= hold_d;
            last_kern_q <= last_kern_d;
        end
    end

    // Read return: capture array data on a read grant, pulse rvalid next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            kern_rvalid <= 1'b0;
            kern_rdata  <= '0;
        end else begin
            host_rvalid <= host_gnt & ~host_we;
            kern_rvalid <= kern_gnt & ~kern_we;
            if (host_gnt && !host_we) host_rdata <= mem_rdata;
            if (kern_gnt && !kern_we) kern_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_arr_port_arbiter.sv
`timescale 1ns/1ps
// Randomized bench for arr_port_arbiter. A reference model tracks the owner,
// the streak length and the last winner, plus a shadow copy of the array.
module tb_arr_port_arbiter;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              host_req, host_we, kern_req, kern_we;
    logic [ADDR_W-1:0] host_addr, kern_addr, mem_addr;
    logic [DATA_W-1:0] host_wdata, kern_wdata, mem_wdata, mem_rdata;
    logic [DATA_W-1:0] host_rdata, kern_rdata;
    logic              host_gnt, kern_gnt, host_rvalid, kern_rvalid, mem_we;

    arr_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .kern_req(kern_req), .kern_we(kern_we), .kern_addr(kern_addr), .kern_wdata(kern_wdata),
        .kern_gnt(kern_gnt), .kern_rvalid(kern_rvalid), .kern_rdata(kern_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Array attached to the arbiter: combinational read, synchronous write
    logic              mem_clr;
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_clr) for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    // Reference model state (0 = none, 1 = host, 2 = kernel)
    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    int                m_owner, m_streak, m_last;
    bit                exp_hrv, exp_krv;
    logic [DATA_W-1:0] exp_hrd, exp_krd;

    int                n_vec = 0;
    int                n_err = 0;
    bit [15:0]         gseq;
    int                gidx;
    bit                last_hg, last_kg;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_reset();
        m_owner  = 0;
        m_streak = 0;
        m_last   = 2;
        exp_hrv  = 1'b0;
        exp_krv  = 1'b0;
        exp_hrd  = '0;
        exp_krd  = '0;
    endfunction

    // Who wins this cycle, from the arbitration rules
    function automatic int ref_winner(input bit hr, input bit kr);
        if (!hr && !kr) return 0;
        if (hr != kr) return hr ? 1 : 2;
`ifdef ARB_HOST_PRIORITY_EN
        return 1;
`else
        if (m_owner == 0) return 3 - m_last;
        if (m_streak < int'(MAX_HOLD)) return m_owner;
        return 3 - m_owner;
`endif
    endfunction

    function automatic void ref_advance(input int w);
        if (w == 0) begin
            m_owner  = 0;
            m_streak = 0;
        end else begin
            if (w == m_owner) m_streak = (m_streak < int'(MAX_HOLD)) ? m_streak + 1 : int'(MAX_HOLD);
            else begin
                m_owner  = w;
                m_streak = 1;
            end
            m_last = w;
        end
    endfunction

    function automatic logic [ADDR_W-1:0] pick_addr();
        if ($urandom_range(9) != 0) return ADDR_W'($urandom_range(7));
        return ADDR_W'($urandom);
    endfunction

    // New requests from idle requesters; pending ones stay untouched
    task automatic gen_req(input int p_h, input int p_k, input bit rd_only);
        if (!host_req && int'($urandom_range(99)) < p_h) begin
            host_req   = 1'b1;
            host_we    = rd_only ? 1'b0 : 1'($urandom_range(1));
            host_addr  = pick_addr();
            host_wdata = {$urandom, $urandom};
        end
        if (!kern_req && int'($urandom_range(99)) < p_k) begin
            kern_req   = 1'b1;
            kern_we    = rd_only ? 1'b0 : 1'($urandom_range(1));
            kern_addr  = pick_addr();
            kern_wdata = {$urandom, $urandom};
        end
    endtask

    // One clock cycle: entered shortly after a rising edge, returns 1ns after the next one
    task automatic run_cycle(input int p_h, input int p_k, input bit rd_only);
        int                w;
        bit                we;
        logic [ADDR_W-1:0] ad;
        logic [DATA_W-1:0] wd;
        gen_req(p_h, p_k, rd_only);
        #3;
        w = ref_winner(host_req, kern_req);
        chk("host_gnt", 64'(host_gnt), 64'(w == 1));
        chk("kern_gnt", 64'(kern_gnt), 64'(w == 2));
        chk("host_rvalid", 64'(host_rvalid), 64'(exp_hrv));
        chk("host_rdata", host_rdata, exp_hrd);
        chk("kern_rvalid", 64'(kern_rvalid), 64'(exp_krv));
        chk("kern_rdata", kern_rdata, exp_krd);
        last_hg = host_gnt;
        last_kg = kern_gnt;
        if (gidx < 16) begin
            gseq[gidx] = host_gnt;
            gidx++;
        end
        we = (w == 1) ? host_we   : kern_we;
        ad = (w == 1) ? host_addr : kern_addr;
        wd = (w == 1) ? host_wdata : kern_wdata;
        if (w != 0) begin
            chk("mem_we", 64'(mem_we), 64'(we));
            chk("mem_addr", 64'(mem_addr), 64'(ad));
            chk("mem_wdata", mem_wdata, wd);
        end else begin
            chk("mem_we_idle", 64'(mem_we), 64'd0);
            chk("mem_addr_idle", 64'(mem_addr), 64'd0);
            chk("mem_wdata_idle", mem_wdata, 64'd0);
        end
        exp_hrv = 1'b0;
        exp_krv = 1'b0;
        if (w == 1 && !we) begin exp_hrv = 1'b1; exp_hrd = ref_mem[ad]; end
        if (w == 2 && !we) begin exp_krv = 1'b1; exp_krd = ref_mem[ad]; end
        if (w != 0 && we) ref_mem[ad] = wd;
        if (rst) ref_reset();
        else     ref_advance(w);
        @(posedge clk);
        #1;
        if (w == 1) host_req = 1'b0;
        if (w == 2) kern_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (host_req || kern_req); i++) run_cycle(0, 0, 1'b0);
        chk("drain_done", 64'(host_req | kern_req), 64'd0);
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        kern_req = 1'b0; kern_we = 1'b0; kern_addr = '0; kern_wdata = '0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        ref_reset();
        gseq = '0;
        gidx = 16;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_host_gnt", 64'(host_gnt), 64'd0);
        chk("rst_host_rvalid", 64'(host_rvalid), 64'd0);
        chk("rst_kern_rdata", kern_rdata, 64'd0);
        mem_clr = 1'b0;
        rst = 1'b0;

        // Both read continuously: round-robin in blocks of MAX_HOLD, no idle cycle
        gidx = 0;
        for (int i = 0; i < 12; i++) run_cycle(100, 100, 1'b1);
`ifdef ARB_HOST_PRIORITY_EN
        chk("rr_seq", 64'(gseq[11:0]), 64'hFFF);
`else
        chk("rr_seq", 64'(gseq[11:0]), 64'b1111_0000_1111);
`endif
        gidx = 16;

        // Reset mid-burst clears the read return immediately
        rst = 1'b1;
        #1;
        chk("arst_host_rvalid", 64'(host_rvalid), 64'd0);
        chk("arst_host_rdata", host_rdata, 64'd0);
        chk("arst_kern_rvalid", 64'(kern_rvalid), 64'd0);
        chk("arst_kern_rdata", kern_rdata, 64'd0);
        ref_reset();
        run_cycle(100, 100, 1'b1);
        rst = 1'b0;
        run_cycle(100, 100, 1'b1);
        chk("post_rst_tie_host", 64'(last_hg), 64'd1);
        drain();

        // Host write then kernel read of the same address on the next cycle
        host_req = 1'b1; host_we = 1'b1; host_addr = ADDR_W'(5); host_wdata = 64'h0000_0000_0000_1234;
        run_cycle(0, 0, 1'b0);
        kern_req = 1'b1; kern_we = 1'b0; kern_addr = ADDR_W'(5);
        run_cycle(0, 0, 1'b0);
        chk("wr_rd_kvalid", 64'(kern_rvalid), 64'd1);
        chk("wr_rd_kdata", kern_rdata, 64'h1234);
        chk("wr_rd_hvalid", 64'(host_rvalid), 64'd0);
        drain();

        // Kernel alone: 10 back-to-back reads
        for (int i = 0; i < 10; i++) begin
            run_cycle(0, 100, 1'b1);
            chk("kern_alone_gnt", 64'(last_kg), 64'd1);
        end
        drain();

        // Host burst of 2, one idle cycle, then a tie
        run_cycle(100, 0, 1'b1);
        run_cycle(100, 0, 1'b1);
        drain();
        run_cycle(0, 0, 1'b1);
        run_cycle(100, 100, 1'b1);
`ifdef ARB_HOST_PRIORITY_EN
        chk("idle_tie", 64'(last_kg), 64'd0);
`else
        chk("idle_tie", 64'(last_kg), 64'd1);
`endif

        // Random traffic, request rates changing every segment
        for (int seg = 0; seg < 20; seg++) begin
            int ph, pk;
            ph = (seg % 4 == 0) ? 100 : 15 + int'($urandom_range(85));
            pk = (seg % 5 == 1) ? 100 : 15 + int'($urandom_range(85));
            for (int i = 0; i < 80; i++) run_cycle(ph, pk, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
